fme_candidate_sequencer: RTL and testbench

Controller that drives the 3-bit select of the FME candidate mux. It steps through the six valid candidate codes: 0..2 are rows a/b/c unshifted, 3..5 are rows a/b/c shifted by one. Codes can be masked off per search. For each issued code it hands the select to the downstream cost datapath and collects one cost value. It reports the code with the minimum cost. It sits between the FME top-level control and the candidate mux / SAD unit.

---
 rtl/fme_candidate_sequencer_if.sv | 28 ++
 rtl/fme_candidate_sequencer.sv | 132 +++++++++++++
 tb/tb_fme_candidate_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fme_candidate_sequencer_if.sv
// Candidate-select handshake between the FME candidate sequencer and the
// candidate mux / cost datapath.
`timescale 1ns/1ps
interface fme_candidate_sequencer_if #(
    parameter int COSTWIDTH = 16
);
    logic [2:0]           select;
    logic                 sel_valid;
    logic                 sel_ready;
    logic [COSTWIDTH-1:0] cost_in;
    logic                 cost_valid;

    modport master (
        output select,
        output sel_valid,
        input  sel_ready,
        input  cost_in,
        input  cost_valid
    );

    modport slave (
        input  select,
        input  sel_valid,
        output sel_ready,
        output cost_in,
        output cost_valid
    );
endinterface

// File: rtl/fme_candidate_sequencer.sv
// Steps the FME candidate mux through the enabled candidate codes, collects one
// cost per code and reports the lowest-cost code (ties keep the lower code).
`timescale 1ns/1ps
module fme_candidate_sequencer #(
    parameter int COSTWIDTH = 16,
    parameter int NUM_CAND  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CAND-1:0]  cand_mask,
    output logic                 busy,
    output logic                 done,
    output logic                 best_valid,
    output logic [2:0]           best_select,
    output logic [COSTWIDTH-1:0] best_cost,
    fme_candidate_sequencer_if.master cand
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_COST = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [2:0] SEL_IDLE = 3'b110;
    localparam logic [2:0] LAST_K   = 3'(NUM_CAND - 1);

    state_t              state_r;
    logic [2:0]          k_r;
    logic [NUM_CAND-1:0] mask_r;
    logic [3:0]          scan_s;

    // Returns {found, code} for the lowest enabled code at or above 'from'.
    function automatic logic [3:0] next_cand(input logic [NUM_CAND-1:0] mask,
                                             input logic [2:0] from);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    // Next enabled candidate seen from the current scan index.
    always_comb begin
        scan_s = next_cand(mask_r, k_r);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            k_r            <= 3'd0;
            mask_r         <= {NUM_CAND{1'b0}};
            busy           <= 1'b0;
            done           <= 1'b0;
            best_valid     <= 1'b0;
            best_select    <= 3'd0;
            best_cost      <= {COSTWIDTH{1'b1}};
            cand.select    <= SEL_IDLE;
            cand.sel_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_r      <= cand_mask;
                        best_valid  <= 1'b0;
                        best_select <= 3'd0;
                        best_cost   <= {COSTWIDTH{1'b1}};
                        k_r         <= 3'd0;
                        busy        <= 1'b1;
                        state_r     <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_s[3]) begin
                        k_r            <= scan_s[2:0];
                        cand.select    <= scan_s[2:0];
                        cand.sel_valid <= 1'b1;
                        state_r        <= ISSUE;
                    end else begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end
                end
                ISSUE: begin
                    if (cand.sel_ready) begin
                        cand.sel_valid <= 1'b0;
                        state_r        <= WAIT_COST;
                    end
                end
                WAIT_COST: begin
                    if (cand.cost_valid) begin
                        // Strict compare: an equal cost never displaces the earlier code.
                        if (!best_valid || (cand.cost_in < best_cost)) begin
                            best_cost   <= cand.cost_in;
                            best_select <= k_r;
                            best_valid  <= 1'b1;
                        end
                        cand.select <= SEL_IDLE;
                        if (k_r == LAST_K) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            k_r     <= k_r + 3'd1;
                            state_r <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                    cand.select    <= SEL_IDLE;
                    cand.sel_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fme_candidate_sequencer.sv
// Randomised scoreboard bench for fme_candidate_sequencer: expected codes and
// results are queued at stimulus time and consumed by an independent monitor.
`timescale 1ns/1ps
module tb_fme_candidate_sequencer;

    typedef struct {
        logic        bv;
        logic [2:0]  bs;
        logic [15:0] bc;
        int          lat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cand_mask = 6'd0;
    logic        busy, done, best_valid;
    logic [2:0]  best_select;
    logic [15:0] best_cost;

    fme_candidate_sequencer_if #(.COSTWIDTH(16)) cif ();

    fme_candidate_sequencer #(.COSTWIDTH(16), .NUM_CAND(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cand_mask   (cand_mask),
        .busy        (busy),
        .done        (done),
        .best_valid  (best_valid),
        .best_select (best_select),
        .best_cost   (best_cost),
        .cand        (cif)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          mode = 0;
    int          stall_cnt = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          res_count = 0;
    logic [15:0] cost_tab [0:7];
    int          exp_sel [$];
    res_t        exp_res [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Datapath responder: ready/cost handshakes; cost_in is garbage (0) outside WAIT_COST.
    initial begin
        cif.sel_ready  = 1'b0;
        cif.cost_valid = 1'b0;
        cif.cost_in    = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: begin
                    cif.sel_ready  = 1'b1;
                    cif.cost_valid = 1'b1;
                end
                1: begin
                    cif.sel_ready  = 1'($urandom_range(0, 1));
                    cif.cost_valid = 1'($urandom_range(0, 1));
                end
                default: begin
                    if (cif.sel_valid === 1'b1 && cif.select === 3'd2 && stall_cnt < 5) begin
                        cif.sel_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        cif.sel_ready = 1'b1;
                    end
                    cif.cost_valid = 1'b1;
                end
            endcase
            cif.cost_in = (cif.select < 3'd6 && cif.sel_valid === 1'b0) ? cost_tab[cif.select] : 16'h0000;
        end
    end

    // Monitor: consumes expected codes on handshakes and expected results on done.
    initial begin
        logic       prev_v, prev_r, prev_done;
        logic [2:0] prev_sel;
        res_t       r;
        prev_v = 1'b0; prev_r = 1'b0; prev_done = 1'b0; prev_sel = 3'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_v = 1'b0; prev_r = 1'b0; prev_done = 1'b0;
                continue;
            end
            if (start === 1'b1 && busy === 1'b0) start_cyc = cyc;
            if (busy === 1'b0) begin
                chk("idle_select", 32'(cif.select), 32'(3'b110));
                chk("idle_sel_valid", 32'(cif.sel_valid), 32'd0);
            end
            if (prev_v && !prev_r) begin
                chk("stall_sel_valid_held", 32'(cif.sel_valid), 32'd1);
                chk("stall_select_stable", 32'(cif.select), 32'(prev_sel));
            end
            if (cif.sel_valid === 1'b1 && cif.sel_ready === 1'b1) begin
                chk("issue_expected", 32'(exp_sel.size() > 0), 32'd1);
                if (exp_sel.size() > 0) chk("issue_code", 32'(cif.select), 32'(exp_sel.pop_front()));
            end
            if (prev_done) chk("done_single_cycle", 32'(done), 32'd0);
            if (done === 1'b1) begin
                chk("done_expected", 32'(exp_res.size() > 0), 32'd1);
                chk("busy_in_done", 32'(busy), 32'd1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    chk("best_valid", 32'(best_valid), 32'(r.bv));
                    chk("best_select", 32'(best_select), 32'(r.bs));
                    chk("best_cost", 32'(best_cost), 32'(r.bc));
                    if (r.lat >= 0) chk("done_latency", 32'(cyc - start_cyc), 32'(r.lat));
                end
                res_count++;
            end
            prev_v = cif.sel_valid; prev_r = cif.sel_ready;
            prev_sel = cif.select; prev_done = done;
        end
    end

    // Reference model: scan enabled codes in ascending order, keep the first strict minimum.
    task automatic push_model(input logic [5:0] m, input int md, output res_t r);
        int n;
        r.bv = 1'b0; r.bs = 3'd0; r.bc = 16'hFFFF;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (m[c]) begin
                exp_sel.push_back(c);
                n++;
                if (!r.bv || cost_tab[c] < r.bc) begin
                    r.bv = 1'b1; r.bs = 3'(c); r.bc = cost_tab[c];
                end
            end
        end
        // One start cycle, three cycles per candidate, a final empty scan unless code 5 ended it.
        r.lat = (md == 0) ? (1 + 3 * n + ((n == 0 || !m[5]) ? 1 : 0)) : -1;
        exp_res.push_back(r);
    endtask

    task automatic pulse_start(input logic [5:0] m);
        @(posedge clk); #1;
        start = 1'b1; cand_mask = m;
        @(posedge clk); #1;
        start = 1'b0; cand_mask = 6'($urandom);
    endtask

    task automatic run_search(input logic [5:0] m, input int md, input bit mid_start);
        res_t r;
        int   prev_cnt;
        mode = md;
        stall_cnt = 0;
        prev_cnt = res_count;
        push_model(m, md, r);
        pulse_start(m);
        if (mid_start) begin
            repeat (6) @(posedge clk);
            pulse_start(6'b000001);
        end
        for (int i = 0; i < 3000 && res_count == prev_cnt; i++) @(negedge clk);
        chk("search_completes", 32'(res_count != prev_cnt), 32'd1);
        if (md == 2) chk("stall_cycles", 32'(stall_cnt), 32'd5);
        repeat (3) @(negedge clk);
        chk("hold_best_valid", 32'(best_valid), 32'(r.bv));
        chk("hold_best_select", 32'(best_select), 32'(r.bs));
        chk("hold_best_cost", 32'(best_cost), 32'(r.bc));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_select"}, 32'(cif.select), 32'(3'b110));
        chk({tag, "_sel_valid"}, 32'(cif.sel_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_best_valid"}, 32'(best_valid), 32'd0);
        chk({tag, "_best_select"}, 32'(best_select), 32'd0);
        chk({tag, "_best_cost"}, 32'(best_cost), 32'h0000_FFFF);
    endtask

    task automatic set_costs(input int c0, input int c1, input int c2,
                             input int c3, input int c4, input int c5);
        cost_tab[0] = 16'(c0); cost_tab[1] = 16'(c1); cost_tab[2] = 16'(c2);
        cost_tab[3] = 16'(c3); cost_tab[4] = 16'(c4); cost_tab[5] = 16'(c5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) cost_tab[i] = 16'h0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_reset");

        set_costs(40, 30, 50, 30, 10, 60);
        run_search(6'b111111, 0, 1'b0);
        set_costs(25, 25, 25, 25, 25, 25);
        run_search(6'b111111, 0, 1'b0);
        set_costs(100, 9, 0, 3, 1, 7);
        run_search(6'b101010, 0, 1'b0);
        run_search(6'b000000, 0, 1'b0);
        set_costs(40, 30, 5, 30, 10, 60);
        run_search(6'b111111, 2, 1'b1);
        set_costs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_search(6'b100100, 0, 1'b0);

        // Reset while waiting for the cost of code 3: no done, all reset values.
        set_costs(8, 7, 6, 5, 4, 3);
        begin
            res_t r;
            mode = 0;
            push_model(6'b111111, 0, r);
            pulse_start(6'b111111);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (cif.sel_valid === 1'b0 && cif.select === 3'd3) break;
            end
            chk("reached_wait_code3", 32'(cif.select), 32'd3);
            exp_sel.delete();
            exp_res.delete();
            rst = 1'b1;
            @(negedge clk);
            check_reset_vals("mid_reset");
            rst = 1'b0;
            repeat (5) @(negedge clk);
        end
        set_costs(12, 11, 13, 2, 14, 2);
        run_search(6'b111111, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int c = 0; c < 6; c++) begin
                case ($urandom_range(0, 3))
                    0:       cost_tab[c] = 16'hFFFF;
                    1:       cost_tab[c] = 16'($urandom_range(0, 7));
                    default: cost_tab[c] = 16'($urandom);
                endcase
            end
            run_search((t % 8 == 7) ? 6'd0 : 6'($urandom), int'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("exp_sel_drained", 32'(exp_sel.size()), 32'd0);
        chk("exp_res_drained", 32'(exp_res.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
